// File: rtl/virtio_irq_pkg.sv
// Shared types and helpers for the virtio interrupt generator.
// ISR bit assignments and pacing-counter sizing live here.
package virtio_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COAL,
    ST_REQ,
    ST_GAP
  } irq_state_e;

  localparam int ISR_QUEUE = 0;
  localparam int ISR_CFG   = 1;

  // Width that holds the largest of the three pacing intervals without wrapping.
  function automatic int cnt_width(input int tmo, input int gap, input int coal);
    int m;
    m = tmo;
    if (gap > m)  m = gap;
    if (coal > m) m = coal;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/virtio_irq_gen_pace_cnt.sv
// Loadable saturating down-counter shared by the timeout, gap and coalesce timing.
// done is high whenever the count sits at zero.
module irq_pace_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/virtio_irq_gen.sv
// Interrupt source: sticky ISR pending bits, paced request/grant handshake.
// Optional macro VIRTIO_IRQ_COALESCE_EN inserts a coalescing window before each request.
module virtio_irq_gen
  import virtio_irq_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int TMO_CYC  = 32,
  parameter int GAP_CYC  = 4,
  parameter int COAL_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NSRC-1:0] src_pulse,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            isr_rd,
  output logic [NSRC-1:0] isr_rdata,
  output logic            intx_msi_request,
  input  logic            intx_msi_grant,
  output logic            irq_pending,
  output logic            grant_tmo
);

  localparam int CW = cnt_width(TMO_CYC, GAP_CYC, COAL_CYC);

  irq_state_e      state, state_nxt;
  logic [NSRC-1:0] pending, pending_nxt;
  logic [NSRC-1:0] signalled, signalled_nxt;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] new_bits, mark;
  logic            new_evt;
  logic            cnt_load, cnt_done, tmo_hit;
  logic [CW-1:0]   cnt_val;

  irq_pace_cnt #(.W(CW)) u_pace (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Mask is registered so unmasking a pending bit has the same latency as a fresh pulse.
  assign new_bits = pending & ~mask_q & ~signalled;
  assign new_evt  = |new_bits;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    mark      = '0;
    tmo_hit   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (new_evt) begin
`ifdef VIRTIO_IRQ_COALESCE_EN
          state_nxt = ST_COAL;
          cnt_load  = 1'b1;
          cnt_val   = CW'(COAL_CYC - 1);
`else
          state_nxt = ST_REQ;
          cnt_load  = 1'b1;
          cnt_val   = CW'(TMO_CYC - 1);
          mark      = new_bits;
`endif
        end
      end
      ST_COAL: begin
`ifdef VIRTIO_IRQ_COALESCE_EN
        // Everything still unannounced at expiry rides on one request.
        if (!new_evt) begin
          state_nxt = ST_IDLE;
        end else if (cnt_done) begin
          state_nxt = ST_REQ;
          cnt_load  = 1'b1;
          cnt_val   = CW'(TMO_CYC - 1);
          mark      = new_bits;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_REQ: begin
        if (intx_msi_grant) begin
          state_nxt = ST_GAP;
          cnt_load  = 1'b1;
          cnt_val   = CW'(GAP_CYC - 1);
        end else if (cnt_done) begin
          state_nxt = ST_GAP;
          cnt_load  = 1'b1;
          cnt_val   = CW'(GAP_CYC - 1);
          tmo_hit   = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A read clears everything except pulses landing in the same cycle; signalled
  // never outlives its pending bit, so a later re-pulse is always announced.
  assign pending_nxt   = isr_rd ? src_pulse : (pending | src_pulse);
  assign signalled_nxt = (isr_rd ? mark : (signalled | mark)) & pending_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      pending          <= '0;
      signalled        <= '0;
      mask_q           <= '0;
      isr_rdata        <= '0;
      intx_msi_request <= 1'b0;
    end else begin
      state            <= state_nxt;
      pending          <= pending_nxt;
      signalled        <= signalled_nxt;
      mask_q           <= irq_mask;
      intx_msi_request <= (state_nxt == ST_REQ);
      if (isr_rd) isr_rdata <= pending;
    end
  end

  assign irq_pending = |pending;
  // Timeout flags the last REQ cycle itself, so it is decoded rather than registered.
  assign grant_tmo   = tmo_hit;

endmodule

// File: tb/tb_virtio_irq_gen.sv
// Self-checking bench for virtio_irq_gen: table-driven ISR vectors plus
// scoreboarded request timing sequences (coalesce sequence under VIRTIO_IRQ_COALESCE_EN).
module tb_virtio_irq_gen;
  import virtio_irq_pkg::*;

  localparam int NSRC = 4;
  localparam int TMO  = 32;
  localparam int GAP  = 4;
  localparam int COAL = 16;
`ifdef VIRTIO_IRQ_COALESCE_EN
  localparam int LAT = 2 + COAL;
`else
  localparam int LAT = 2;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b1;
  logic [NSRC-1:0] src_pulse = '0;
  logic [NSRC-1:0] irq_mask = '0;
  logic            isr_rd = 1'b0;
  logic [NSRC-1:0] isr_rdata;
  logic            intx_msi_request;
  logic            intx_msi_grant = 1'b0;
  logic            irq_pending;
  logic            grant_tmo;

  virtio_irq_gen #(.NSRC(NSRC), .TMO_CYC(TMO), .GAP_CYC(GAP), .COAL_CYC(COAL)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .src_pulse        (src_pulse),
    .irq_mask         (irq_mask),
    .isr_rd           (isr_rd),
    .isr_rdata        (isr_rdata),
    .intx_msi_request (intx_msi_request),
    .intx_msi_grant   (intx_msi_grant),
    .irq_pending      (irq_pending),
    .grant_tmo        (grant_tmo)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  int              exp_rise_q[$];
  logic [NSRC-1:0] exp_rd_q[$];
  int              fall_q[$];
  int              tmo_q[$];
  logic            rd_pend  = 1'b0;
  logic            req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards as the DUT produces read data and request edges.
  always @(negedge i_clk) begin
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL isr_rdata_unexpected: got %0d with no read queued", isr_rdata);
      end else begin
        check("isr_rdata", 32'(isr_rdata), 32'(exp_rd_q.pop_front()));
      end
    end
    rd_pend = isr_rd;
    if (intx_msi_request === 1'b1 && req_prev === 1'b0) begin
      if (exp_rise_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_req: got rise at cycle %0d, expected none", cyc);
      end else begin
        check("req_rise_cycle", cyc, exp_rise_q.pop_front());
      end
    end
    if (intx_msi_request === 1'b0 && req_prev === 1'b1) fall_q.push_back(cyc);
    if (grant_tmo === 1'b1) tmo_q.push_back(cyc);
    req_prev = intx_msi_request;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NSRC-1:0] bits);
    src_pulse = bits;
    step();
    src_pulse = '0;
  endtask

  task automatic isr_read(input logic [NSRC-1:0] exp);
    exp_rd_q.push_back(exp);
    isr_rd = 1'b1;
    step();
    isr_rd = 1'b0;
  endtask

  task automatic grant_pulse();
    intx_msi_grant = 1'b1;
    step();
    intx_msi_grant = 1'b0;
  endtask

  task automatic do_reset();
    check("missed_req", exp_rise_q.size(), 0);
    exp_rise_q.delete();
    src_pulse      = '0;
    irq_mask       = '0;
    isr_rd         = 1'b0;
    intx_msi_grant = 1'b0;
    i_rst_n        = 1'b0;
    #1;
    check("rst_request", 32'(intx_msi_request), 0);
    check("rst_irq_pending", 32'(irq_pending), 0);
    check("rst_grant_tmo", 32'(grant_tmo), 0);
    check("rst_isr_rdata", 32'(isr_rdata), 0);
    step(2);
    i_rst_n = 1'b1;
    step();
    fall_q.delete();
    tmo_q.delete();
  endtask

  typedef struct {
    logic [NSRC-1:0] src;
    logic            rd;
    logic [NSRC-1:0] rdata;
    logic            pend;
  } vec_t;

  vec_t vecs[8];
  int   p;
  int   q;

  initial begin
    vecs[0] = '{4'h1, 1'b0, 4'h0, 1'b1};
    vecs[1] = '{4'h4, 1'b0, 4'h0, 1'b1};
    vecs[2] = '{4'h0, 1'b1, 4'h5, 1'b0};
    vecs[3] = '{4'h8, 1'b1, 4'h0, 1'b1};
    vecs[4] = '{4'h0, 1'b1, 4'h8, 1'b0};
    vecs[5] = '{4'h2, 1'b0, 4'h0, 1'b1};
    vecs[6] = '{4'h1, 1'b1, 4'h2, 1'b1};
    vecs[7] = '{4'h0, 1'b1, 4'h1, 1'b0};

    step();
    do_reset();

    // Pending/ISR register behaviour with every source masked (no requests).
    irq_mask = '1;
    step(2);
    for (int i = 0; i < 8; i++) begin
      src_pulse = vecs[i].src;
      isr_rd    = vecs[i].rd;
      if (vecs[i].rd) exp_rd_q.push_back(vecs[i].rdata);
      step();
      src_pulse = '0;
      isr_rd    = 1'b0;
      @(negedge i_clk);
      check($sformatf("tbl%0d_irq_pending", i), 32'(irq_pending), 32'(vecs[i].pend));
      step();
    end

    // Single event, grant tied low: full timeout, then gap.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'(1 << ISR_QUEUE));
    step(LAT + TMO + GAP + 10);
    check("a_fall_count", fall_q.size(), 1);
    check("a_fall_cycle", fall_q.size() > 0 ? fall_q[0] : -1, p + LAT + TMO);
    check("a_tmo_count", tmo_q.size(), 1);
    check("a_tmo_cycle", tmo_q.size() > 0 ? tmo_q[0] : -1, p + LAT + TMO - 1);
    @(negedge i_clk);
    check("a_irq_pending", 32'(irq_pending), 1);
    step();
    isr_read(4'h1);
    @(negedge i_clk);
    check("a_cleared", 32'(irq_pending), 0);
    step(3);

    // Grant two cycles after the rise ends the request the next cycle.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'(1 << ISR_CFG));
    step(LAT + 1);
    grant_pulse();
    step(GAP + 4);
    check("b_fall_cycle", fall_q.size() > 0 ? fall_q[0] : -1, p + LAT + 3);
    check("b_no_tmo", tmo_q.size(), 0);
    isr_read(4'h2);
    @(negedge i_clk);
    check("b_cleared", 32'(irq_pending), 0);
    step(3);

    // Event during REQ is held and raised after the gap.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'h1);
    step(LAT + 1);
    exp_rise_q.push_back(p + 2 * LAT + TMO + GAP - 1);
    pulse(4'h4);
    step(LAT + 2 * TMO + GAP + 8);
    check("c_fall_count", fall_q.size(), 2);
    check("c_tmo_count", tmo_q.size(), 2);
    isr_read(4'h5);
    step(2);

    // Masked source pends silently; unmasking raises the request.
    do_reset();
    irq_mask = 4'h1;
    step(2);
    pulse(4'h1);
    step(8);
    @(negedge i_clk);
    check("d_masked_pending", 32'(irq_pending), 1);
    step();
    irq_mask = 4'h0;
    exp_rise_q.push_back(cyc + LAT);
    step(LAT + 3);
    check("d_unmask_rise", exp_rise_q.size(), 0);

    // Read and pulse in the same cycle: set wins, old value returned.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'h1);
    step(LAT);
    grant_pulse();
    step(GAP + 4);
    q = cyc;
    exp_rd_q.push_back(4'h1);
    exp_rise_q.push_back(q + LAT);
    src_pulse = 4'h8;
    isr_rd    = 1'b1;
    step();
    src_pulse = '0;
    isr_rd    = 1'b0;
    step(LAT + 1);
    grant_pulse();
    step(GAP + 3);
    isr_read(4'h8);
    @(negedge i_clk);
    check("e_cleared", 32'(irq_pending), 0);
    step(2);

    // Reset while the request is high drops it at once and forgets the event.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'h1);
    step(LAT + 2);
    check("f_req_high", 32'(intx_msi_request), 1);
    i_rst_n = 1'b0;
    #1;
    check("f_req_in_reset", 32'(intx_msi_request), 0);
    check("f_pending_in_reset", 32'(irq_pending), 0);
    step(2);
    i_rst_n = 1'b1;
    step(LAT + TMO + 5);
    check("f_no_req_after", exp_rise_q.size(), 0);

`ifdef VIRTIO_IRQ_COALESCE_EN
    // Three pulses inside one window merge into a single request.
    do_reset();
    p = cyc;
    exp_rise_q.push_back(p + LAT);
    pulse(4'h1);
    step(2);
    pulse(4'h2);
    step(4);
    pulse(4'h4);
    step(LAT + TMO + GAP + 10);
    check("g_tmo_count", tmo_q.size(), 1);
    isr_read(4'h7);
    step(2);
`endif

    do_reset();
    check("rd_scoreboard_drained", exp_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/virtio_irq_gen.md
Name: virtio_irq_gen

Overview:
Interrupt source side of the host interrupt path. It collects per-event pulses from the virtio device logic (queue used-buffer, config change, etc.) into a sticky ISR-style pending register and issues `intx_msi_request` toward the PCIe/QEMU bridge, which acts on the request's rising edge. It owns handshake pacing: it waits for `intx_msi_grant` or a timeout, then enforces a low gap so every new event produces a clean rising edge. The host clears pending bits through an ISR read-to-clear strobe.

Parameters:
NSRC, 4, number of interrupt event sources (ISR bit i = source i)
TMO_CYC, 32, cycles to wait for grant before giving up on the current request (grant may be tied low)
GAP_CYC, 4, minimum cycles request is held low between requests (>=1)
COAL_CYC, 16, coalescing window in cycles (used only with the optional feature)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
src_pulse  input  NSRC  single-cycle event pulses, one per source
irq_mask  input  NSRC  1 = source may set pending but never triggers a request
isr_rd  input  1  single-cycle ISR read strobe; read-to-clear
isr_rdata  output  NSRC  pending snapshot, valid in the cycle after isr_rd
intx_msi_request  output  1  interrupt request to the bridge, registered
intx_msi_grant  input  1  grant from the bridge
irq_pending  output  1  OR of pending bits
grant_tmo  output  1  one-cycle pulse when a request ends by timeout

Behaviour:
- Reset: async assert, sync deassert handled upstream. Clears pending, signalled, isr_rdata, counters and FSM=IDLE. All outputs are 0 while reset is asserted. A request in flight drops immediately.
- `pending[i]` set by `src_pulse[i]`, cleared only by `isr_rd`. If `src_pulse[i]` and `isr_rd` occur in the same cycle, set wins. `isr_rdata` returns the pre-clear value, including bits already set before that cycle.
- `signalled[i]` marks bits already announced by a request. It is cleared together with pending on `isr_rd`, except bits set in that same cycle.
- `new_evt` = |(pending & ~irq_mask & ~signalled).
- FSM:
  - IDLE: if `new_evt`, go to REQ, set `intx_msi_request`=1, and OR the triggering bits into `signalled`.
  - REQ: request held high; the timeout counter counts up.
    - If grant=1, go to GAP.
    - If the count reaches TMO_CYC-1 with no grant, pulse `grant_tmo` and go to GAP.
    - Request drops on entry to GAP.
  - GAP: request low for exactly GAP_CYC cycles, then go to IDLE.
- Events arriving during REQ or GAP are not lost. They remain unsignalled and trigger the next request from IDLE.
- Latency: pulse at cycle N sets pending at N+1; request rises at N+2 (IDLE, unmasked, no coalescing).
- Unmasking a pending, unsignalled bit triggers a request exactly as a new event does.
- A grant seen while in IDLE or GAP is ignored.
- Counters are sized $clog2(max(TMO_CYC, GAP_CYC, COAL_CYC)+1) and saturate; they never wrap.

Optional Feature:
VIRTIO_IRQ_COALESCE_EN
- Defined: adds a COAL state between IDLE and REQ.
  - The first `new_evt` starts a COAL_CYC counter.
  - When the counter expires, request once, marking all bits unsignalled at that cycle.
  - Extra events inside the window merge into that single request.
  - `isr_rd` clearing all new bits during COAL aborts to IDLE with no request.
- Undefined: no COAL state; latency is exactly as stated in Behaviour.

Decomposition:
- Package `virtio_irq_pkg`:
  - FSM state enum (IDLE, COAL, REQ, GAP)
  - ISR bit index constants (ISR_QUEUE=0, ISR_CFG=1)
  - counter-width function
- One natural sub-module, `irq_pace_cnt`: a loadable saturating down-counter with a done flag, shared by the TMO, GAP and COAL timing.

Test Plan:
- Single event: src_pulse[0] at cycle 10, grant tied 0 → request rises at 12, stays high 32 cycles, `grant_tmo` pulses at 43, low for 4 cycles; pending stays 0x1.
- Grant path: src_pulse[1], grant=1 two cycles after the request rises → request falls the next cycle, no `grant_tmo`. isr_rd then gives isr_rdata=0x2 and pending becomes 0.
- Event during REQ: src[0], then src[2] while in REQ → exactly two request rising edges, the second no earlier than GAP_CYC cycles after the first falls. isr_rdata=0x5.
- Mask/unmask: irq_mask=0x1, src[0] → no request, irq_pending=1. Clearing the mask → request rises two cycles later.
- Set/clear collision: isr_rd and src_pulse[3] in the same cycle with pending 0x1 → isr_rdata=0x1, pending becomes 0x8, and a new request follows.
- Reset mid-REQ: assert i_rst_n=0 while request is high → request is 0 in the same cycle. After release, no request occurs until a new pulse. With the coalesce macro: 3 pulses inside 16 cycles produce 1 request.
